// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter
// Hands the shared data-memory bus between the MIPS MEM stage and the 8237
// DMA controller. A DMA hold request is only acknowledged once the CPU's
// in-flight memory access has drained. The pipeline stays frozen for the whole
// time the DMA owns the bus, and for a short idle turnaround after it lets go.
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output.

module dma_bus_arbiter #(
    parameter int DRAIN_CYCLES = 1,
    parameter int TURNAROUND   = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hrq,
    input  logic             mem_busy,
    input  logic             clr_count,
    output logic             hlda,
    output logic             pipe_stall,
    output logic             bus_sel,
    output logic [CNT_W-1:0] hold_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_GRANT   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int TRN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [TRN_W-1:0] TURN_LOAD  = TRN_W'(TURNAROUND - 1);

    logic [1:0]       state, state_nxt;
    logic [DRN_W-1:0] drain_cnt, drain_nxt;
    logic [TRN_W-1:0] turn_cnt, turn_nxt;

    // Next-state and counter logic. mem_busy is only looked at while draining.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        turn_nxt  = turn_cnt;
        case (state)
            ST_IDLE: begin
                if (hrq) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!hrq) begin
                    state_nxt = ST_IDLE;
                end else if (drain_cnt == '0 && !mem_busy) begin
                    state_nxt = ST_GRANT;
                end else if (drain_cnt != '0) begin
                    drain_nxt = drain_cnt - DRN_W'(1);
                end
            end
            ST_GRANT: begin
                if (!hrq) begin
                    state_nxt = ST_RELEASE;
                    turn_nxt  = TURN_LOAD;
                end
            end
            ST_RELEASE: begin
                if (turn_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    turn_nxt = turn_cnt - TRN_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and outputs. Outputs are decoded from the next state so
    // that they line up with the state register without an extra cycle of lag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            drain_cnt  <= '0;
            turn_cnt   <= '0;
            hlda       <= 1'b0;
            bus_sel    <= 1'b0;
            pipe_stall <= 1'b0;
        end else begin
            state      <= state_nxt;
            drain_cnt  <= drain_nxt;
            turn_cnt   <= turn_nxt;
            hlda       <= (state_nxt == ST_GRANT);
            bus_sel    <= (state_nxt == ST_GRANT);
            pipe_stall <= (state_nxt != ST_IDLE);
        end
    end

    // Saturating count of GRANT cycles. A clear takes precedence over an increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_count <= '0;
        end else if (clr_count) begin
            hold_count <= '0;
        end else if (state == ST_GRANT && hold_count != {CNT_W{1'b1}}) begin
            hold_count <= hold_count + CNT_W'(1);
        end
    end

endmodule
